// File: rtl/j2c_slave.sv
// J2C link receiver: synchronizes sda/scl, decodes START/STOP/BIT and rebuilds MSB-first words.
// Define J2C_SLAVE_PARITY_EN to expect a trailing even-parity bit and report parity_err.
module j2c_slave #(
  parameter int MESSAGE_LENGTH = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sda,
  input  logic                      scl,
  output logic [MESSAGE_LENGTH-1:0] data,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      parity_err
);

`ifdef J2C_SLAVE_PARITY_EN
  localparam int FRAME_BITS = MESSAGE_LENGTH + 1;
`else
  localparam int FRAME_BITS = MESSAGE_LENGTH;
`endif
  localparam int CNT_W = $clog2(MESSAGE_LENGTH + 2);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RECEIVE   = 2'd1;
  localparam logic [1:0] WAIT_STOP = 2'd2;
  localparam logic [1:0] STOP_CLK  = 2'd3;

  logic [SYNC_STAGES-1:0] sda_sync, scl_sync;
  logic                   sda_prev, scl_prev;
  logic                   sda_s, scl_s;
  logic                   start_cond, stop_cond, bit_cond, scl_fall;

  logic [1:0]            state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [FRAME_BITS-1:0] shift, shift_next;
  logic                  commit, commit_next;
  logic                  ferr_next;

  // NOTE: every clocked assignment is non-blocking so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_sync <= '1;
      scl_sync <= '1;
      sda_prev <= 1'b1;
      scl_prev <= 1'b1;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_prev <= sda_s;
      scl_prev <= scl_s;
    end
  end

  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];

  // START/STOP need scl steady high; an sda edge coinciding with an scl edge decodes as BIT only.
  assign start_cond = scl_s & scl_prev & ~sda_s &  sda_prev;
  assign stop_cond  = scl_s & scl_prev &  sda_s & ~sda_prev;
  assign bit_cond   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;

  // NOTE: each signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shift_next  = shift;
    commit_next = 1'b0;
    ferr_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start_cond) begin
          state_next = RECEIVE;
          cnt_next   = '0;
        end
      end
      RECEIVE: begin
        if (start_cond) begin
          cnt_next = '0;
        end else if (stop_cond) begin
          ferr_next  = 1'b1;
          state_next = IDLE;
        end else if (bit_cond) begin
          shift_next = {shift[FRAME_BITS-2:0], sda_s};
          cnt_next   = cnt + CNT_W'(1);
          if (cnt_next == FRAME_CNT) state_next = WAIT_STOP;
        end
      end
      // The STOP itself needs one scl rise after the last bit; a surplus bit is only
      // distinguishable from it once scl falls again without a STOP.
      WAIT_STOP, STOP_CLK: begin
        if (stop_cond) begin
          commit_next = 1'b1;
          state_next  = IDLE;
        end else if (start_cond) begin
          ferr_next  = 1'b1;
          state_next = RECEIVE;
          cnt_next   = '0;
        end else if (state == WAIT_STOP && bit_cond) begin
          state_next = STOP_CLK;
        end else if (state == STOP_CLK && scl_fall) begin
          ferr_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      commit     <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
`ifdef J2C_SLAVE_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shift      <= shift_next;
      commit     <= commit_next;
      busy       <= (state_next != IDLE);
      frame_err  <= ferr_next;
      data_valid <= 1'b0;
`ifdef J2C_SLAVE_PARITY_EN
      parity_err <= 1'b0;
      if (commit) begin
        if (^shift == 1'b0) begin
          data       <= shift[FRAME_BITS-1:1];
          data_valid <= 1'b1;
        end else begin
          parity_err <= 1'b1;
        end
      end
`else
      if (commit) begin
        data       <= shift;
        data_valid <= 1'b1;
      end
`endif
    end
  end

`ifndef J2C_SLAVE_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_j2c_slave.sv
// Self-checking bench for j2c_slave: bit-banged J2C master plus a word/latency scoreboard.
module tb_j2c_slave;
  localparam int ML = 8;
  localparam int SS = 2;
  localparam int PH = 4;
`ifdef J2C_SLAVE_PARITY_EN
  localparam int FB = ML + 1;
`else
  localparam int FB = ML;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sda = 1'b1;
  logic          scl = 1'b1;
  logic [ML-1:0] data;
  logic          data_valid, busy, frame_err, parity_err;

  j2c_slave #(.MESSAGE_LENGTH(ML), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl),
    .data(data), .data_valid(data_valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ML-1:0] exp_q[$];
  int            stop_q[$];
  int            n_checks = 0, n_pass = 0;
  int            dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  logic [ML-1:0] mon_exp;
  int            mon_stop;

  // Scoreboard: each data_valid pops the oldest expected word and its STOP cycle.
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (data_valid) begin
      dv_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: data=%h but no word expected", data);
      end else begin
        n_pass++;
        mon_exp  = exp_q.pop_front();
        mon_stop = stop_q.pop_front();
        n_checks++;
        if (data !== mon_exp) $display("FAIL data_word: got %h want %h", data, mon_exp);
        else n_pass++;
        n_checks++;
        if (cyc - mon_stop !== SS + 2)
          $display("FAIL valid_latency: got %0d want %0d", cyc - mon_stop, SS + 2);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start;
    sda = 1'b1; hold(PH);
    scl = 1'b1; hold(PH);
    sda = 1'b0; hold(PH);
    scl = 1'b0; hold(PH);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    hold(PH);
    scl = 1'b1; hold(PH);
    scl = 1'b0; hold(PH);
  endtask

  task automatic send_stop(input bit good, input logic [ML-1:0] w);
    sda = 1'b0; hold(PH);
    scl = 1'b1; hold(PH);
    sda = 1'b1;
    if (good) begin
      exp_q.push_back(w);
      stop_q.push_back(cyc);
    end
    hold(PH);
  endtask

  task automatic send_word(input logic [ML-1:0] w);
    for (int i = ML - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_tail(input logic [ML-1:0] w);
    send_word(w);
`ifdef J2C_SLAVE_PARITY_EN
    send_bit(^w);
`endif
    send_stop(1'b1, w);
  endtask

  task automatic send_frame(input logic [ML-1:0] w);
    send_start;
    send_tail(w);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      hold(1);
      t++;
    end
    hold(2);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: %0d words pending, want 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; hold(3);
    reset = 1'b0; hold(50);
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (dv_cnt !== 0) $display("FAIL reset_valid: got %0d pulses want 0", dv_cnt); else n_pass++;
    n_checks++; if (ferr_cnt !== 0) $display("FAIL reset_frame_err: got %0d want 0", ferr_cnt); else n_pass++;
    n_checks++; if (perr_cnt !== 0) $display("FAIL reset_parity_err: got %0d want 0", perr_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int dv0, f0;
    dv0 = dv_cnt; f0 = ferr_cnt;
    send_frame(8'h5F);
    send_frame(8'h95);
    send_frame(8'hF0);
    send_frame(8'h0F);
    drain("b2b");
    n_checks++; if (dv_cnt - dv0 !== 4) $display("FAIL b2b_valid_count: got %0d want 4", dv_cnt - dv0); else n_pass++;
    n_checks++; if (ferr_cnt !== f0) $display("FAIL b2b_frame_err: got %0d want %0d", ferr_cnt, f0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_short_frame;
    int dv0, f0;
    logic [ML-1:0] w;
    dv0 = dv_cnt; f0 = ferr_cnt; w = 8'h95;
    send_start;
    n_checks++; if (busy !== 1'b1) $display("FAIL short_busy: got %b want 1", busy); else n_pass++;
    for (int i = ML - 1; i >= ML - 5; i--) send_bit(w[i]);
    send_stop(1'b0, w);
    hold(4);
    n_checks++; if (ferr_cnt - f0 !== 1) $display("FAIL short_frame_err: got %0d want 1", ferr_cnt - f0); else n_pass++;
    n_checks++; if (dv_cnt !== dv0) $display("FAIL short_no_valid: got %0d want %0d", dv_cnt, dv0); else n_pass++;
    n_checks++; if (data !== 8'h0F) $display("FAIL short_data_kept: got %h want 0f", data); else n_pass++;
    send_frame(8'hF0);
    drain("short_next");
    n_checks++; if (data !== 8'hF0) $display("FAIL short_next_data: got %h want f0", data); else n_pass++;
  endtask

  task automatic test_repeated_start;
    int dv0, f0;
    dv0 = dv_cnt; f0 = ferr_cnt;
    send_start;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_start;
    send_tail(8'h5F);
    drain("rstart");
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL rstart_valid_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (ferr_cnt !== f0) $display("FAIL rstart_frame_err: got %0d want %0d", ferr_cnt, f0); else n_pass++;
    n_checks++; if (data !== 8'h5F) $display("FAIL rstart_data: got %h want 5f", data); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int dv0, f0;
    dv0 = dv_cnt; f0 = ferr_cnt;
    send_start;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1; hold(1);
    reset = 1'b0; hold(1);
    n_checks++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    sda = 1'b1; hold(PH);
    scl = 1'b1; hold(PH);
    send_frame(8'h0F);
    drain("midrst");
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL midrst_valid_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (ferr_cnt !== f0) $display("FAIL midrst_frame_err: got %0d want %0d", ferr_cnt, f0); else n_pass++;
    n_checks++; if (data !== 8'h0F) $display("FAIL midrst_next_data: got %h want 0f", data); else n_pass++;
  endtask

  task automatic test_too_many_bits;
    int dv0, f0;
    dv0 = dv_cnt; f0 = ferr_cnt;
    send_start;
    for (int i = 0; i < FB + 1; i++) send_bit(1'b1);
    hold(PH);
    n_checks++; if (ferr_cnt - f0 !== 1) $display("FAIL overflow_frame_err: got %0d want 1", ferr_cnt - f0); else n_pass++;
    n_checks++; if (dv_cnt !== dv0) $display("FAIL overflow_no_valid: got %0d want %0d", dv_cnt, dv0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL overflow_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (data !== 8'h0F) $display("FAIL overflow_data_kept: got %h want 0f", data); else n_pass++;
    sda = 1'b1; hold(PH);
    scl = 1'b1; hold(PH);
  endtask

`ifdef J2C_SLAVE_PARITY_EN
  task automatic test_parity;
    int dv0, p0;
    dv0 = dv_cnt; p0 = perr_cnt;
    send_start;
    send_word(8'h95);
    send_bit(1'b0);
    send_stop(1'b1, 8'h95);
    drain("parity_ok");
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL parity_ok_valid: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (data !== 8'h95) $display("FAIL parity_ok_data: got %h want 95", data); else n_pass++;
    dv0 = dv_cnt;
    send_start;
    send_word(8'h95);
    send_bit(1'b1);
    send_stop(1'b0, 8'h95);
    hold(4);
    n_checks++; if (perr_cnt - p0 !== 1) $display("FAIL parity_bad_err: got %0d want 1", perr_cnt - p0); else n_pass++;
    n_checks++; if (dv_cnt !== dv0) $display("FAIL parity_bad_valid: got %0d want %0d", dv_cnt, dv0); else n_pass++;
    n_checks++; if (data !== 8'h95) $display("FAIL parity_bad_data: got %h want 95", data); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_back_to_back;
    test_short_frame;
    test_repeated_start;
    test_reset_mid_frame;
    test_too_many_bits;
`ifdef J2C_SLAVE_PARITY_EN
    test_parity;
`else
    n_checks++; if (perr_cnt !== 0) $display("FAIL parity_tied_off: got %0d pulses want 0", perr_cnt); else n_pass++;
`endif
    hold(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/j2c_slave.md
Name: j2c_slave

Overview:
- Receiving end of the J2C two-wire link: samples `sda`/`scl` driven by the J2C master and rebuilds each MESSAGE_LENGTH-bit word.
- Sits on the far side of the bus from the master; pure listener, never drives `sda` or `scl`.
- Presents each completed word on a parallel output with a one-cycle valid strobe.
- Flags malformed frames.

Parameters:
- MESSAGE_LENGTH, 8, data bits per frame (>=2).
- SYNC_STAGES, 2, synchronizer flops on `sda`/`scl` (>=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sda  input  1  serial data line from master.
- scl  input  1  serial clock line from master.
- data  output  MESSAGE_LENGTH  last good received word, MSB = first bit on the wire.
- data_valid  output  1  one-cycle pulse when `data` updates.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse on a malformed frame.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 unless the optional feature is compiled in.

Behaviour:
- Reset:
  - `data` = 0; `data_valid`, `busy`, `frame_err`, `parity_err` = 0.
  - Synchronizer and previous-sample flops = 1 (bus idle high).
  - Bit counter = 0; state = IDLE.
  - Reset asserted mid-frame discards the partial word; no strobes fire.
- Input conditioning:
  - `sda` and `scl` each pass through SYNC_STAGES flops, plus one flop holding the previous synchronized value.
  - Edge and condition detection uses only synchronized values.
  - The master must hold each `scl` phase for at least 3 `clk` cycles.
- Bus conditions (synchronized signals):
  - START: `sda` 1->0 while `scl` = 1.
  - STOP: `sda` 0->1 while `scl` = 1.
  - BIT: `scl` 0->1; `sda` is sampled in that same cycle.
  - `sda` edges while `scl` = 0 are ignored.
- State machine:
  - IDLE:
    - START -> RECEIVE, counter cleared.
    - BIT and STOP are ignored.
  - RECEIVE:
    - Each BIT shifts `sda` into the shift register LSB (MSB-first on the wire) and increments the counter.
    - When the counter reaches FRAME_BITS -> WAIT_STOP. FRAME_BITS = MESSAGE_LENGTH, or MESSAGE_LENGTH+1 with the option.
    - STOP before FRAME_BITS bits -> pulse `frame_err`, go to IDLE, `data` unchanged.
    - START (repeated start) -> discard the partial word, clear the counter, stay in RECEIVE, no error.
  - WAIT_STOP:
    - STOP -> register the word into `data`, pulse `data_valid` in the next cycle, go to IDLE.
    - Another BIT (too many bits) -> pulse `frame_err`, go to IDLE.
    - START -> pulse `frame_err`, go to RECEIVE with counter cleared.
- Latency: `data_valid` rises exactly SYNC_STAGES+2 `clk` cycles after the raw `sda` 0->1 edge that forms STOP.
- Counter width is $clog2(MESSAGE_LENGTH+2). It never wraps; overflow is the too-many-bits error above.
- Simultaneous `scl` and `sda` transitions in the same synchronized cycle:
  - Treated as BIT only (sda sampled at its new value).
  - No START/STOP is decoded.
- `data` holds its value between frames; only a good frame updates it.
- `busy` is registered and equals (state != IDLE).

Optional Feature:
- Macro: J2C_SLAVE_PARITY_EN.
- Defined:
  - Frame is MESSAGE_LENGTH data bits followed by one even-parity bit (XOR of data and parity = 0).
  - On STOP with a parity mismatch: pulse `parity_err` instead of `data_valid`, leave `data` unchanged.
  - On STOP with parity OK: normal `data_valid`.
- Undefined:
  - Frame is MESSAGE_LENGTH bits; `parity_err` is tied to 0.
  - No parity logic is synthesized.

Test Plan:
- Reset then idle bus (`sda` = `scl` = 1) for 50 cycles -> `data` = 0x00, no strobes, `busy` = 0.
- Frames 8'b01011111, 8'b10010101, 8'b11110000, 8'b00001111 back-to-back, each START/8 bits/STOP -> four `data_valid` pulses with `data` = 0x5F, 0x95, 0xF0, 0x0F in order, each SYNC_STAGES+2 cycles after STOP.
- START, 5 bits of 0x95, then STOP -> `frame_err` pulse, no `data_valid`, `data` keeps previous 0x0F; next full frame 0xF0 received correctly.
- START, 3 bits, repeated START, full 0x5F, STOP -> one `data_valid` with 0x5F, no `frame_err`.
- Reset pulsed for 1 cycle mid-frame after 4 bits, then full frame 0x0F -> `data` = 0 after reset, then 0x0F with one `data_valid`; 9 bits sent without STOP -> `frame_err`.
- With J2C_SLAVE_PARITY_EN:
  - 0x95 + parity 0 -> `data_valid`, `data` = 0x95.
  - 0x95 + parity 1 -> `parity_err`, `data` unchanged.
